// File: rtl/gemm_operand_skewer_if.sv
// Operand/edge bundle between the GEMM operand feeder and its neighbours.
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// The master holds a_col/b_row stable while in_valid is high. in_ready never
// waits on in_valid.
interface gemm_operand_skewer_if #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int KW = 5
);
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_col;
   logic [N*DW-1:0] b_row;
   logic [N*DW-1:0] edge_a;
   logic [N*DW-1:0] edge_b;
   logic            edge_valid;
   logic            acc_clear;
   logic            done;
   logic [2:0]      dbg_state;

   modport master (
      output start, k_len, in_valid, a_col, b_row,
      input  busy, in_ready, edge_a, edge_b, edge_valid, acc_clear, done, dbg_state
   );

   modport slave (
      input  start, k_len, in_valid, a_col, b_row,
      output busy, in_ready, edge_a, edge_b, edge_valid, acc_clear, done, dbg_state
   );
endinterface

// File: rtl/gemm_operand_skewer.sv
// Feeds a 4x4 systolic GEMM array: accepts A-column/B-row beats, skews lane i
// by i cycles, then flushes zeros and sequences clear/load/flush/done.
module gemm_operand_skewer #(
   parameter int N     = 4,
   parameter int DW    = 16,
   parameter int K_MAX = 16,
   parameter int KW    = $clog2(K_MAX + 1)
) (
   input logic clk,
   input logic rst_n,
   gemm_operand_skewer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_DONE} state_t;

   // Long enough for the last beat to cross the skew and the whole array.
   localparam int FLUSH_CYC = 3 * N - 2;
   localparam int FW        = $clog2(FLUSH_CYC + 1);

   state_t          r_state;
   state_t          w_next;
   logic [KW-1:0]   r_k_len;
   logic [KW-1:0]   r_beat_cnt;
   logic [FW-1:0]   r_flush_cnt;
   logic            r_edge_valid;
   logic            w_accept;
   logic            w_busy;
   logic            w_in_ready;
   logic            w_acc_clear;
   logic            w_done;
   logic [N*DW-1:0] w_a_in;
   logic [N*DW-1:0] w_b_in;

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_a_in   = w_accept ? bus.a_col : '0;
   assign w_b_in   = w_accept ? bus.b_row : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_k_len      <= '0;
         r_beat_cnt   <= '0;
         r_flush_cnt  <= '0;
         r_edge_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && bus.start)
            r_k_len <= (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
         if (r_state == S_CLEAR)
            r_beat_cnt <= '0;
         else if (w_accept)
            r_beat_cnt <= r_beat_cnt + KW'(1);
         r_flush_cnt  <= (r_state == S_FLUSH) ? r_flush_cnt + FW'(1) : '0;
         r_edge_valid <= w_accept;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_busy      = 1'b1;
      w_in_ready  = 1'b0;
      w_acc_clear = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_acc_clear = 1'b1;
            w_next      = (r_k_len == '0) ? S_FLUSH : S_LOAD;
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && r_beat_cnt == r_k_len - KW'(1)) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            if (r_flush_cnt == FW'(FLUSH_CYC - 1)) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.busy       = w_busy;
   assign bus.in_ready   = w_in_ready;
   assign bus.acc_clear  = w_acc_clear;
   assign bus.done       = w_done;
   assign bus.edge_valid = r_edge_valid;
   assign bus.dbg_state  = r_state;

   // Lane i: i skew stages plus the output register, element [i] drives the edge.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] r_a_sr [0:i];
      logic [DW-1:0] r_b_sr [0:i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= i; s++) begin
               r_a_sr[s] <= '0;
               r_b_sr[s] <= '0;
            end
         end else begin
            r_a_sr[0] <= w_a_in[i*DW +: DW];
            r_b_sr[0] <= w_b_in[i*DW +: DW];
            for (int s = 1; s <= i; s++) begin
               r_a_sr[s] <= r_a_sr[s-1];
               r_b_sr[s] <= r_b_sr[s-1];
            end
         end
      end

      assign bus.edge_a[i*DW +: DW] = r_a_sr[i];
      assign bus.edge_b[i*DW +: DW] = r_b_sr[i];
   end

endmodule

// File: tb/tb_gemm_operand_skewer.sv
// Bench for gemm_operand_skewer with a behavioural 4x4 output-stationary
// systolic array attached to the edge lanes.
module tb_gemm_operand_skewer;
   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int K_MAX = 16;
   localparam int KW    = $clog2(K_MAX + 1);
   localparam int KS    = 20;
   localparam int AW    = 40;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gemm_operand_skewer_if #(.N(N), .DW(DW), .KW(KW)) bus ();

   gemm_operand_skewer #(.N(N), .DW(DW), .K_MAX(K_MAX), .KW(KW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Array model: A flows right along rows, B flows down columns.
   logic signed [AW-1:0] pa  [N][N];
   logic signed [AW-1:0] pb  [N][N];
   logic signed [AW-1:0] ain [N][N];
   logic signed [AW-1:0] bin [N][N];
   logic signed [AW-1:0] acc [N][N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            ain[i][j] = (j == 0) ? AW'($signed(bus.edge_a[i*DW +: DW])) : pa[i][(j == 0) ? 0 : j-1];
            bin[i][j] = (i == 0) ? AW'($signed(bus.edge_b[j*DW +: DW])) : pb[(i == 0) ? 0 : i-1][j];
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!rst_n) begin
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
               acc[i][j] <= '0;
            end else begin
               pa[i][j]  <= ain[i][j];
               pb[i][j]  <= bin[i][j];
               acc[i][j] <= bus.acc_clear ? '0 : acc[i][j] + ain[i][j] * bin[i][j];
            end
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int a_m [N][KS];
   int b_m [KS][N];

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // 0: identity, 1: signed corner values, 2: ramp long enough for k_len=20
   task automatic load_set(input int kind);
      int sa [N][N] = '{'{-32768, 3, -5, 7}, '{2, -4, 6, -8},
                        '{100, -200, 300, 32767}, '{-1, -1, 1, 1}};
      int sb [N][N] = '{'{-32768, 1, 2, 3}, '{5, -6, 7, -8},
                        '{-9, 10, 1000, -12}, '{13, 14, -15, 32767}};
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < KS; k++) begin
            case (kind)
               0:       begin a_m[i][k] = (i == k) ? 1 : 0;   b_m[k][i] = (i == k) ? 1 : 0; end
               1:       begin a_m[i][k] = (k < N) ? sa[i][k] : 0; b_m[k][i] = (k < N) ? sb[k][i] : 0; end
               default: begin a_m[i][k] = (i + 1) * (k + 1) - 7; b_m[k][i] = 3 - k * (i + 2); end
            endcase
         end
      end
   endtask

   task automatic drive_beat(input int k);
      for (int i = 0; i < N; i++) begin
         bus.a_col[i*DW +: DW] = DW'(a_m[i][k]);
         bus.b_row[i*DW +: DW] = DW'(b_m[k][i]);
      end
   endtask

   task automatic check_c(input string tag, input int klen);
      longint g;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            g = 0;
            for (int k = 0; k < klen; k++) g += longint'(a_m[i][k]) * longint'(b_m[k][j]);
            check($sformatf("%s_c%0d%0d", tag, i, j), longint'(acc[i][j]), g);
         end
      end
   endtask

   task automatic check_ident(input string tag);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            check($sformatf("%s_c%0d%0d", tag, i, j), longint'(acc[i][j]), (i == j) ? 1 : 0);
   endtask

   // Called one step after a clock edge; returns one step into the IDLE cycle after done.
   task automatic run_job(input int klen, input int nsup, input bit stall, input bit hold_valid,
                          input bit poke_start, output int lat, output int n_clr,
                          output int n_acc, output int n_ev);
      int  beat;
      bit  phase;
      beat = 0; phase = 0; lat = -1; n_clr = 0; n_acc = 0; n_ev = 0;
      bus.k_len = KW'(klen);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (bus.acc_clear) n_clr++;
         if (bus.edge_valid) n_ev++;
         if (bus.done) begin
            lat = c;
            break;
         end
         bus.in_valid = 1'b0;
         bus.start    = poke_start && bus.in_ready;
         if (hold_valid) begin
            bus.in_valid = 1'b1;
            drive_beat((beat < nsup) ? beat : 0);
         end else if (bus.in_ready && beat < nsup) begin
            if (stall && !phase) phase = 1'b1;
            else begin
               phase        = 1'b0;
               bus.in_valid = 1'b1;
               drive_beat(beat);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            beat++;
            n_acc++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, n_clr, n_acc, n_ev, c;
      logic [N*DW-1:0] exp_a, exp_b;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
      bus.a_col = '0;   bus.b_row = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.in_ready, 0);
      check("rst_state", bus.dbg_state, 0);

      // T1: reset in the middle of LOAD with nonzero lanes
      load_set(1);
      bus.k_len = KW'(4); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; drive_beat(0);
      @(posedge clk); #1 drive_beat(1);
      @(posedge clk); #1;
      check("t1_pre_nonzero", bus.edge_a != '0, 1);
      rst_n = 1'b0;
      #1;
      check("t1_edge_a", bus.edge_a, 0);
      check("t1_edge_b", bus.edge_b, 0);
      check("t1_busy", bus.busy, 0);
      check("t1_ready", bus.in_ready, 0);
      check("t1_ev", bus.edge_valid, 0);
      check("t1_clr", bus.acc_clear, 0);
      check("t1_done", bus.done, 0);
      check("t1_state", bus.dbg_state, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t1_ready_after", bus.in_ready, 0);
         check("t1_ev_after", bus.edge_valid, 0);
      end
      bus.in_valid = 1'b0;

      // T2: single beat, skew timing per lane
      bus.k_len = KW'(1); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      check("t2_clear", bus.acc_clear, 1);
      @(posedge clk); #1;
      check("t2_ready", bus.in_ready, 1);
      bus.a_col = {16'd4, 16'd3, 16'd2, 16'd1};
      bus.b_row = {16'd8, 16'd7, 16'd6, 16'd5};
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0;
      for (c = 1; c <= 5; c++) begin
         exp_a = '0; exp_b = '0;
         for (int i = 0; i < N; i++) begin
            if (c == i + 1) begin
               exp_a[i*DW +: DW] = DW'(i + 1);
               exp_b[i*DW +: DW] = DW'(i + 5);
            end
         end
         check($sformatf("t2_edge_a_c%0d", c), bus.edge_a, exp_a);
         check($sformatf("t2_edge_b_c%0d", c), bus.edge_b, exp_b);
         check($sformatf("t2_ev_c%0d", c), bus.edge_valid, (c == 1) ? 1 : 0);
         @(posedge clk); #1;
      end
      while (!bus.done && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      check("t2_done_lat", c, 3 * N - 2 + 1);
      @(posedge clk); #1;
      check("t2_idle", bus.busy, 0);

      // T3: identity, then signed corner values, no stalls
      load_set(0);
      run_job(4, 4, 0, 0, 0, lat, n_clr, n_acc, n_ev);
      check("t3i_lat", lat, 15);
      check("t3i_clr", n_clr, 1);
      check("t3i_ev", n_ev, 4);
      check_ident("t3i");
      load_set(1);
      run_job(4, 4, 0, 0, 0, lat, n_clr, n_acc, n_ev);
      check("t3s_lat", lat, 15);
      check("t3s_c00_hand", longint'(acc[0][0]), 64'sd1073741975);
      check_c("t3s", 4);

      // T4: same signed job with one stall before every beat
      run_job(4, 4, 1, 0, 0, lat, n_clr, n_acc, n_ev);
      check("t4_lat", lat, 15 + 4);
      check("t4_acc", n_acc, 4);
      check_c("t4", 4);

      // T5: k_len=0 with in_valid held high, saturation, start during LOAD
      run_job(0, 0, 0, 1, 0, lat, n_clr, n_acc, n_ev);
      check("t5z_lat", lat, 11);
      check("t5z_clr", n_clr, 1);
      check("t5z_acc", n_acc, 0);
      check("t5z_ev", n_ev, 0);
      check_c("t5z", 0);
      load_set(2);
      run_job(20, 20, 0, 0, 0, lat, n_clr, n_acc, n_ev);
      check("t5s_acc", n_acc, 16);
      check("t5s_lat", lat, 27);
      check_c("t5s", 16);
      load_set(0);
      run_job(4, 4, 0, 0, 1, lat, n_clr, n_acc, n_ev);
      check("t5p_lat", lat, 15);
      check("t5p_clr", n_clr, 1);
      check("t5p_idle", bus.busy, 0);

      // T6: back-to-back jobs, second must carry no residue of the first
      load_set(1);
      run_job(4, 4, 0, 0, 0, lat, n_clr, n_acc, n_ev);
      check_c("t6a", 4);
      load_set(0);
      run_job(4, 4, 0, 0, 0, lat, n_clr, n_acc, n_ev);
      check("t6b_clr", n_clr, 1);
      check("t6b_lat", lat, 15);
      check_ident("t6b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
